// File: rtl/ex_mmul_unit_pkg.sv
// Shared types and constants for the EX-stage multiply-accumulate unit.
// Optional accumulator saturation is enabled by defining MMUL_SAT_EN.
package ex_mmul_unit_pkg;

  localparam int MUL_ITER = 8;
  localparam int ACC_W    = 16;
  localparam int RES_W    = 8;
  localparam int DEST_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } mmul_state_t;

  // EX/MEM result mux select: the multiplier result wins only on its valid pulse.
  typedef enum logic {
    EXM_SEL_ALU  = 1'b0,
    EXM_SEL_MMUL = 1'b1
  } exm_sel_t;

  function automatic exm_sel_t exm_sel(input logic mm_valid);
    return mm_valid ? EXM_SEL_MMUL : EXM_SEL_ALU;
  endfunction

endpackage

// File: rtl/ex_mmul_unit_core.sv
// Shift-add multiply core: captures operands on start, then accumulates one
// partial product per cycle while run is asserted.
module mmul_shift_add_core #(
  parameter int MUL_W  = 8,
  parameter int DEST_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 run,
  input  logic                 abort,
  input  logic [MUL_W-1:0]     a,
  input  logic [MUL_W-1:0]     b,
  input  logic                 clr,
  input  logic [DEST_W-1:0]    destreg,
  output logic [2*MUL_W-1:0]   product,
  output logic                 done,
  output logic                 clr_q,
  output logic [DEST_W-1:0]    destreg_q
);
  import ex_mmul_unit_pkg::*;

  localparam int CNT_W  = $clog2(MUL_ITER);
  localparam int PROD_W = 2 * MUL_W;

  logic [MUL_W-1:0] a_q;
  logic [MUL_W-1:0] b_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: every register here is reset, including the datapath, because
  // mm_destreg is visible at the top and must read 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      product   <= '0;
      clr_q     <= 1'b0;
      destreg_q <= '0;
    end else if (start) begin
      a_q       <= a;
      b_q       <= b;
      clr_q     <= clr;
      destreg_q <= destreg;
      cnt_q     <= '0;
      product   <= '0;
    end else if (run && !abort) begin
      if (b_q[cnt_q])
        product <= product + (PROD_W'(a_q) << cnt_q);
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done = run && (cnt_q == CNT_W'(MUL_ITER - 1));

endmodule

// File: rtl/ex_mmul_unit.sv
// EX-stage matrix multiply-accumulate unit: FSM, accumulator and stall/valid.
// Define MMUL_SAT_EN for a saturating accumulator and clamped result byte.
module ex_mmul_unit #(
  parameter int MUL_W = 8,
  parameter int ACC_W = ex_mmul_unit_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_matrix_mult_e,
  input  logic [MUL_W-1:0] SrcAE,
  input  logic [MUL_W-1:0] SrcBE,
  input  logic             acc_clr_e,
  input  logic [2:0]       destreg_e,
  input  logic             abort,
  output logic             StallMM,
  output logic             mm_valid,
  output logic [7:0]       mm_result,
  output logic [2:0]       mm_destreg,
  output logic [ACC_W-1:0] acc_out
);
  import ex_mmul_unit_pkg::*;

  mmul_state_t state_q, state_d;

  logic               start;
  logic               core_done;
  logic               clr_q;
  logic [2*MUL_W-1:0] product;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   acc_new;
`ifdef MMUL_SAT_EN
  logic [ACC_W:0]     acc_sum;
`endif

  mmul_shift_add_core #(
    .MUL_W  (MUL_W),
    .DEST_W (DEST_W)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .run       (state_q == ST_MUL),
    .abort     (abort),
    .a         (SrcAE),
    .b         (SrcBE),
    .clr       (acc_clr_e),
    .destreg   (destreg_e),
    .product   (product),
    .done      (core_done),
    .clr_q     (clr_q),
    .destreg_q (mm_destreg)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (is_matrix_mult_e && !abort) state_d = ST_MUL;
      ST_MUL:  if (abort)                      state_d = ST_IDLE;
               else if (core_done)             state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: defaults first in every combinational block so no path infers a latch.
  always_comb begin
    start    = (state_q == ST_IDLE) && is_matrix_mult_e && !abort;
    StallMM  = start || (state_q == ST_MUL);
    mm_valid = (state_q == ST_DONE) && !abort;
  end

  always_comb begin
    acc_base = clr_q ? '0 : acc_q;
    prod_ext = ACC_W'(product);
`ifdef MMUL_SAT_EN
    acc_sum  = {1'b0, acc_base} + {1'b0, prod_ext};
    acc_new  = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
    acc_new  = acc_base + prod_ext;
`endif
    // The updated sum is visible during DONE; the register catches up on exit.
    acc_out  = mm_valid ? acc_new : acc_q;
`ifdef MMUL_SAT_EN
    mm_result = (|acc_out[ACC_W-1:RES_W]) ? 8'hFF : acc_out[RES_W-1:0];
`else
    mm_result = acc_out[RES_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset)        acc_q <= '0;
    else if (mm_valid) acc_q <= acc_new;
  end

endmodule
